// File: rtl/est_sync_saida_4fases_if.sv
// Bundle between the synchronous sink stage, its upstream four-phase source
// and the clocked consumer that drains the FIFO.
interface est_sync_saida_4fases_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         data_in;
  logic                     req_in;
  logic                     ack_prev;
  logic [WIDTH-1:0]         data_out;
  logic                     valid_out;
  logic                     ready_in;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output data_in, req_in, ready_in,
    input  ack_prev, data_out, valid_out, count
  );

  modport slave (
    input  data_in, req_in, ready_in,
    output ack_prev, data_out, valid_out, count
  );
endinterface

// File: rtl/est_sync_saida_4fases.sv
// Synchronous sink for a four-phase bundled-data pipeline: synchronises req,
// buffers tokens in a first-word-fall-through FIFO, holds ack while full.
//
// state        | meaning
// ESPERA_REQ   | ack low, waiting for synchronised req with a free slot
// ESPERA_BAIXO | token written, ack high, waiting for req to return low
module est_sync_saida_4fases #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  est_sync_saida_4fases_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ESPERA_REQ, ESPERA_BAIXO} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   ack_q;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count_q;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  // req_in is the only asynchronous input; data_in is stable by the write edge
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Full uses the registered count, so a same-cycle pop never enables a push
  assign push  = (state == ESPERA_REQ) && req_s && !full;
  assign pop   = !empty && bus.ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ESPERA_REQ;
      ack_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      case (state)
        ESPERA_REQ: begin
          if (push) begin
            ack_q <= 1'b1;
            state <= ESPERA_BAIXO;
          end
        end
        ESPERA_BAIXO: begin
          if (!req_s) begin
            ack_q <= 1'b0;
            state <= ESPERA_REQ;
          end
        end
        default: begin
          ack_q <= 1'b0;
          state <= ESPERA_REQ;
        end
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  assign bus.ack_prev  = ack_q;
  assign bus.valid_out = !empty;
  assign bus.count     = count_q;
  assign bus.data_out  = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_est_sync_saida_4fases.sv
// Bench for est_sync_saida_4fases: four-phase source driver, expected-token
// queue and a negedge monitor that checks every pop and the occupancy.
module tb_est_sync_saida_4fases;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;  // edges counted from the first edge after req changes

  logic clk = 1'b0;
  logic rst = 1'b1;

  est_sync_saida_4fases_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  est_sync_saida_4fases #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  int  occ     = 0;
  int  max_cnt = 0;
  bit  mon_en  = 0;
  bit  ack_was = 0;
  bit  pop_was = 0;
  bit  rst_was = 0;
  bit  stop_toggle = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: occupancy model from observed writes (ack rising) and pops
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_was) begin
        occ = 0;
        exp_q.delete();
      end else begin
        if (pop_was) occ--;
        if (bus.ack_prev && !ack_was) occ++;
      end
      chk("count_vs_model", bus.count, occ);
      chk("valid_vs_model", bus.valid_out, occ != 0);
      if (occ == 0) chk("data_out_empty", bus.data_out, 0);
      if (int'(bus.count) > max_cnt) max_cnt = bus.count;
      pop_was = bus.valid_out && bus.ready_in && !rst;
      if (pop_was) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_data", bus.data_out, exp_q.pop_front());
      end
    end
    ack_was = bus.ack_prev;
    rst_was = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_req(input logic [WIDTH-1:0] d);
    tick();
    bus.data_in = d;
    bus.req_in  = 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic wait_ack(input logic lvl, input int exp_n, input string nm);
    int n = 999;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.ack_prev == lvl) begin
        n = i;
        break;
      end
    end
    chk(nm, n, exp_n);
  endtask

  task automatic drop_req();
    tick();
    bus.req_in = 1'b0;
    wait_ack(1'b0, LAT, "ack_fall_lat");
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    raise_req(d);
    wait_ack(1'b1, LAT, "ack_rise_lat");
    drop_req();
  endtask

  task automatic drain();
    int left = 999;
    tick();
    bus.ready_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.count == 0) begin
        left = 0;
        break;
      end
    end
    bus.ready_in = 1'b0;
    chk("drain_empty", left, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] d;
    bus.data_in  = '0;
    bus.req_in   = 1'b0;
    bus.ready_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ack", bus.ack_prev, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_data", bus.data_out, 0);
    mon_en = 1;

    // Single token with first-word fall-through
    raise_req(8'h56);
    wait_ack(1'b1, LAT, "single_ack_lat");
    chk("single_valid", bus.valid_out, 1);
    chk("single_data", bus.data_out, 8'h56);
    chk("single_count", bus.count, 1);
    drop_req();
    drain();

    // Stream with a consumer always ready
    bus.ready_in = 1'b1;
    max_cnt = 0;
    for (int i = 1; i <= 16; i++) send(8'(i));
    repeat (3) tick();
    chk("stream_max_count", max_cnt, 1);
    chk("stream_all_popped", exp_q.size(), 0);
    bus.ready_in = 1'b0;

    // Back-pressure: fill, then a fifth request must wait for a pop
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    chk("bp_count_full", bus.count, 4);
    raise_req(8'hA4);
    repeat (10) tick();
    chk("bp_ack_held", bus.ack_prev, 0);
    chk("bp_count_held", bus.count, 4);
    tick();
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    chk("bp_count_after_pop", bus.count, 3);
    chk("bp_ack_not_yet", bus.ack_prev, 0);
    tick();
    chk("bp_ack_next_edge", bus.ack_prev, 1);
    chk("bp_count_refill", bus.count, 4);
    drop_req();
    drain();
    chk("bp_all_popped", exp_q.size(), 0);

    // Held request writes exactly once
    d = 8'($urandom);
    raise_req(d);
    wait_ack(1'b1, LAT, "held_ack_lat");
    repeat (20) begin
      tick();
      chk("held_ack", bus.ack_prev, 1);
      chk("held_count", bus.count, 1);
    end
    drop_req();
    drain();

    // Wrap-around with ready toggling every cycle
    stop_toggle = 0;
    fork
      while (!stop_toggle) begin
        tick();
        bus.ready_in = ~bus.ready_in;
      end
    join_none
    for (int i = 0; i < 10; i++) send(8'($urandom));
    stop_toggle = 1;
    repeat (3) tick();
    bus.ready_in = 1'b0;
    drain();
    chk("wrap_all_popped", exp_q.size(), 0);

    // Reset mid-handshake with three tokens buffered
    for (int i = 0; i < 2; i++) send(8'($urandom));
    raise_req(8'($urandom));
    wait_ack(1'b1, LAT, "rst_pre_ack_lat");
    chk("rst_pre_count", bus.count, 3);
    tick();
    rst = 1'b1;
    bus.req_in = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_ack", bus.ack_prev, 0);
    chk("midrst_valid", bus.valid_out, 0);
    chk("midrst_data", bus.data_out, 0);
    chk("midrst_count", bus.count, 0);
    d = 8'($urandom);
    raise_req(d);
    wait_ack(1'b1, LAT, "post_rst_ack_lat");
    chk("post_rst_data", bus.data_out, d);
    chk("post_rst_count", bus.count, 1);
    drop_req();
    drain();
    repeat (2) tick();
    chk("final_all_popped", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
